// File: rtl/tl_arb_pkg.sv
// Shared TileLink A-channel arbiter definitions: opcodes, beat count, FSM states.
package tl_arb_pkg;

   localparam int unsigned DATA_W     = 64;
   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned SRC_W      = 4;
   localparam int unsigned MASK_W     = 8;
   localparam int unsigned BEAT_CNT_W = 4;
   localparam int unsigned BEATS_W    = 5;

   localparam logic [2:0] OP_PUT_FULL    = 3'd0;
   localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
   localparam logic [2:0] OP_ARITH       = 3'd2;
   localparam logic [2:0] OP_LOGIC       = 3'd3;
   localparam logic [2:0] OP_GET         = 3'd4;
   localparam logic [2:0] OP_HINT        = 3'd5;
   localparam logic [2:0] OP_ACQ_BLOCK   = 3'd6;
   localparam logic [2:0] OP_ACQ_PERM    = 3'd7;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic [2:0]        opcode;
      logic [2:0]        param;
      logic [2:0]        size;
      logic [SRC_W-1:0]  source;
      logic [ADDR_W-1:0] address;
      logic [MASK_W-1:0] mask;
      logic [DATA_W-1:0] data;
      logic              corrupt;
   } tl_a_bits_t;

   // Beats in an A message: dataless opcodes and sub-beat sizes are one beat.
   function automatic logic [BEATS_W-1:0] a_beats(input logic [2:0] opcode,
                                                  input logic [2:0] size);
      if (opcode >= OP_GET || size <= 3'd3) return BEATS_W'(1);
      return BEATS_W'(1) << (size - 3'd3);
   endfunction

endpackage

// File: rtl/tl_rr_grant_2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to ptr.
module tl_rr_grant_2 (
   input  logic [1:0] valid,
   input  logic       ptr,
   output logic       grant_any,
   output logic       grant_idx
);

   always_comb begin
      grant_any = |valid;
      grant_idx = (&valid) ? ptr : valid[1];
   end

endmodule

// File: rtl/tl_a_arbiter_2.sv
// Two-client TileLink arbiter: round-robin A channel with burst lock,
// stateless D return routing on the top source bit.
module tl_a_arbiter_2
   import tl_arb_pkg::*;
(
   input  logic        clock,
   input  logic        reset,

   input  logic        in0_a_valid,
   output logic        in0_a_ready,
   input  logic [2:0]  in0_a_bits_opcode,
   input  logic [2:0]  in0_a_bits_param,
   input  logic [2:0]  in0_a_bits_size,
   input  logic [3:0]  in0_a_bits_source,
   input  logic [31:0] in0_a_bits_address,
   input  logic [7:0]  in0_a_bits_mask,
   input  logic [63:0] in0_a_bits_data,
   input  logic        in0_a_bits_corrupt,

   input  logic        in1_a_valid,
   output logic        in1_a_ready,
   input  logic [2:0]  in1_a_bits_opcode,
   input  logic [2:0]  in1_a_bits_param,
   input  logic [2:0]  in1_a_bits_size,
   input  logic [3:0]  in1_a_bits_source,
   input  logic [31:0] in1_a_bits_address,
   input  logic [7:0]  in1_a_bits_mask,
   input  logic [63:0] in1_a_bits_data,
   input  logic        in1_a_bits_corrupt,

   output logic        in0_d_valid,
   input  logic        in0_d_ready,
   output logic [2:0]  in0_d_bits_opcode,
   output logic [1:0]  in0_d_bits_param,
   output logic [2:0]  in0_d_bits_size,
   output logic [3:0]  in0_d_bits_source,
   output logic [2:0]  in0_d_bits_sink,
   output logic        in0_d_bits_denied,
   output logic [63:0] in0_d_bits_data,
   output logic        in0_d_bits_corrupt,

   output logic        in1_d_valid,
   input  logic        in1_d_ready,
   output logic [2:0]  in1_d_bits_opcode,
   output logic [1:0]  in1_d_bits_param,
   output logic [2:0]  in1_d_bits_size,
   output logic [3:0]  in1_d_bits_source,
   output logic [2:0]  in1_d_bits_sink,
   output logic        in1_d_bits_denied,
   output logic [63:0] in1_d_bits_data,
   output logic        in1_d_bits_corrupt,

   output logic        out_a_valid,
   input  logic        out_a_ready,
   output logic [2:0]  out_a_bits_opcode,
   output logic [2:0]  out_a_bits_param,
   output logic [2:0]  out_a_bits_size,
   output logic [4:0]  out_a_bits_source,
   output logic [31:0] out_a_bits_address,
   output logic [7:0]  out_a_bits_mask,
   output logic [63:0] out_a_bits_data,
   output logic        out_a_bits_corrupt,

   input  logic        out_d_valid,
   output logic        out_d_ready,
   input  logic [2:0]  out_d_bits_opcode,
   input  logic [1:0]  out_d_bits_param,
   input  logic [2:0]  out_d_bits_size,
   input  logic [4:0]  out_d_bits_source,
   input  logic [2:0]  out_d_bits_sink,
   input  logic        out_d_bits_denied,
   input  logic [63:0] out_d_bits_data,
   input  logic        out_d_bits_corrupt
);

   tl_a_bits_t            a0, a1, a_sel;
   arb_state_e            state_q, state_d;
   logic                  ptr_q, ptr_d, lock_q, lock_d;
   logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;
   logic                  rr_any, rr_idx, sel, granted, fire, d_sel;
   logic [BEATS_W-1:0]    beats;

   assign a0 = '{opcode: in0_a_bits_opcode, param: in0_a_bits_param, size: in0_a_bits_size,
                 source: in0_a_bits_source, address: in0_a_bits_address, mask: in0_a_bits_mask,
                 data: in0_a_bits_data, corrupt: in0_a_bits_corrupt};
   assign a1 = '{opcode: in1_a_bits_opcode, param: in1_a_bits_param, size: in1_a_bits_size,
                 source: in1_a_bits_source, address: in1_a_bits_address, mask: in1_a_bits_mask,
                 data: in1_a_bits_data, corrupt: in1_a_bits_corrupt};

   tl_rr_grant_2 u_rr (
      .valid     ({in1_a_valid, in0_a_valid}),
      .ptr       (ptr_q),
      .grant_any (rr_any),
      .grant_idx (rr_idx)
   );

   // Grant, handshake and next-state; a burst holds its client until the last beat.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      lock_d  = lock_q;

      sel         = (state_q == ST_BURST) ? lock_q : rr_idx;
      granted     = (state_q == ST_BURST) || rr_any;
      a_sel       = sel ? a1 : a0;
      out_a_valid = !reset && (sel ? in1_a_valid : in0_a_valid);
      in0_a_ready = !reset && granted && !sel && out_a_ready;
      in1_a_ready = !reset && granted && sel && out_a_ready;
      fire        = out_a_valid && out_a_ready;
      beats       = a_beats(a_sel.opcode, a_sel.size);

      case (state_q)
         ST_IDLE: begin
            if (fire) begin
               if (beats > BEATS_W'(1)) begin
                  state_d = ST_BURST;
                  cnt_d   = BEAT_CNT_W'(beats - BEATS_W'(1));
                  lock_d  = sel;
               end else begin
                  ptr_d = ~sel;
               end
            end
         end
         ST_BURST: begin
            if (fire) begin
               cnt_d = cnt_q - BEAT_CNT_W'(1);
               if (cnt_q == BEAT_CNT_W'(1)) begin
                  state_d = ST_IDLE;
                  ptr_d   = ~lock_q;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ptr_q   <= 1'b0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         lock_q  <= lock_d;
      end
   end

   assign out_a_bits_opcode  = a_sel.opcode;
   assign out_a_bits_param   = a_sel.param;
   assign out_a_bits_size    = a_sel.size;
   assign out_a_bits_source  = {sel, a_sel.source};
   assign out_a_bits_address = a_sel.address;
   assign out_a_bits_mask    = a_sel.mask;
   assign out_a_bits_data    = a_sel.data;
   assign out_a_bits_corrupt = a_sel.corrupt;

   // D return: top source bit picks the client, payload fans out to both.
   assign d_sel       = out_d_bits_source[4];
   assign in0_d_valid = !reset && out_d_valid && !d_sel;
   assign in1_d_valid = !reset && out_d_valid && d_sel;
   assign out_d_ready = !reset && (d_sel ? in1_d_ready : in0_d_ready);

   assign in0_d_bits_opcode  = out_d_bits_opcode;
   assign in0_d_bits_param   = out_d_bits_param;
   assign in0_d_bits_size    = out_d_bits_size;
   assign in0_d_bits_source  = out_d_bits_source[3:0];
   assign in0_d_bits_sink    = out_d_bits_sink;
   assign in0_d_bits_denied  = out_d_bits_denied;
   assign in0_d_bits_data    = out_d_bits_data;
   assign in0_d_bits_corrupt = out_d_bits_corrupt;

   assign in1_d_bits_opcode  = out_d_bits_opcode;
   assign in1_d_bits_param   = out_d_bits_param;
   assign in1_d_bits_size    = out_d_bits_size;
   assign in1_d_bits_source  = out_d_bits_source[3:0];
   assign in1_d_bits_sink    = out_d_bits_sink;
   assign in1_d_bits_denied  = out_d_bits_denied;
   assign in1_d_bits_data    = out_d_bits_data;
   assign in1_d_bits_corrupt = out_d_bits_corrupt;

endmodule

// File: tb/tb_tl_a_arbiter_2.sv
// Self-checking bench for tl_a_arbiter_2: vector table, directed corner sequences,
// and randomized traffic against a message-level reference model.
module tb_tl_a_arbiter_2;

   logic        clock, reset;

   logic        in0_a_valid, in0_a_ready, in0_a_bits_corrupt;
   logic [2:0]  in0_a_bits_opcode, in0_a_bits_param, in0_a_bits_size;
   logic [3:0]  in0_a_bits_source;
   logic [31:0] in0_a_bits_address;
   logic [7:0]  in0_a_bits_mask;
   logic [63:0] in0_a_bits_data;

   logic        in1_a_valid, in1_a_ready, in1_a_bits_corrupt;
   logic [2:0]  in1_a_bits_opcode, in1_a_bits_param, in1_a_bits_size;
   logic [3:0]  in1_a_bits_source;
   logic [31:0] in1_a_bits_address;
   logic [7:0]  in1_a_bits_mask;
   logic [63:0] in1_a_bits_data;

   logic        in0_d_valid, in0_d_ready, in0_d_bits_denied, in0_d_bits_corrupt;
   logic [2:0]  in0_d_bits_opcode, in0_d_bits_size, in0_d_bits_sink;
   logic [1:0]  in0_d_bits_param;
   logic [3:0]  in0_d_bits_source;
   logic [63:0] in0_d_bits_data;

   logic        in1_d_valid, in1_d_ready, in1_d_bits_denied, in1_d_bits_corrupt;
   logic [2:0]  in1_d_bits_opcode, in1_d_bits_size, in1_d_bits_sink;
   logic [1:0]  in1_d_bits_param;
   logic [3:0]  in1_d_bits_source;
   logic [63:0] in1_d_bits_data;

   logic        out_a_valid, out_a_ready, out_a_bits_corrupt;
   logic [2:0]  out_a_bits_opcode, out_a_bits_param, out_a_bits_size;
   logic [4:0]  out_a_bits_source;
   logic [31:0] out_a_bits_address;
   logic [7:0]  out_a_bits_mask;
   logic [63:0] out_a_bits_data;

   logic        out_d_valid, out_d_ready, out_d_bits_denied, out_d_bits_corrupt;
   logic [2:0]  out_d_bits_opcode, out_d_bits_size, out_d_bits_sink;
   logic [1:0]  out_d_bits_param;
   logic [4:0]  out_d_bits_source;
   logic [63:0] out_d_bits_data;

   int checks = 0;
   int errors = 0;

   tl_a_arbiter_2 dut (
      .clock(clock), .reset(reset),
      .in0_a_valid(in0_a_valid), .in0_a_ready(in0_a_ready),
      .in0_a_bits_opcode(in0_a_bits_opcode), .in0_a_bits_param(in0_a_bits_param),
      .in0_a_bits_size(in0_a_bits_size), .in0_a_bits_source(in0_a_bits_source),
      .in0_a_bits_address(in0_a_bits_address), .in0_a_bits_mask(in0_a_bits_mask),
      .in0_a_bits_data(in0_a_bits_data), .in0_a_bits_corrupt(in0_a_bits_corrupt),
      .in1_a_valid(in1_a_valid), .in1_a_ready(in1_a_ready),
      .in1_a_bits_opcode(in1_a_bits_opcode), .in1_a_bits_param(in1_a_bits_param),
      .in1_a_bits_size(in1_a_bits_size), .in1_a_bits_source(in1_a_bits_source),
      .in1_a_bits_address(in1_a_bits_address), .in1_a_bits_mask(in1_a_bits_mask),
      .in1_a_bits_data(in1_a_bits_data), .in1_a_bits_corrupt(in1_a_bits_corrupt),
      .in0_d_valid(in0_d_valid), .in0_d_ready(in0_d_ready),
      .in0_d_bits_opcode(in0_d_bits_opcode), .in0_d_bits_param(in0_d_bits_param),
      .in0_d_bits_size(in0_d_bits_size), .in0_d_bits_source(in0_d_bits_source),
      .in0_d_bits_sink(in0_d_bits_sink), .in0_d_bits_denied(in0_d_bits_denied),
      .in0_d_bits_data(in0_d_bits_data), .in0_d_bits_corrupt(in0_d_bits_corrupt),
      .in1_d_valid(in1_d_valid), .in1_d_ready(in1_d_ready),
      .in1_d_bits_opcode(in1_d_bits_opcode), .in1_d_bits_param(in1_d_bits_param),
      .in1_d_bits_size(in1_d_bits_size), .in1_d_bits_source(in1_d_bits_source),
      .in1_d_bits_sink(in1_d_bits_sink), .in1_d_bits_denied(in1_d_bits_denied),
      .in1_d_bits_data(in1_d_bits_data), .in1_d_bits_corrupt(in1_d_bits_corrupt),
      .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
      .out_a_bits_opcode(out_a_bits_opcode), .out_a_bits_param(out_a_bits_param),
      .out_a_bits_size(out_a_bits_size), .out_a_bits_source(out_a_bits_source),
      .out_a_bits_address(out_a_bits_address), .out_a_bits_mask(out_a_bits_mask),
      .out_a_bits_data(out_a_bits_data), .out_a_bits_corrupt(out_a_bits_corrupt),
      .out_d_valid(out_d_valid), .out_d_ready(out_d_ready),
      .out_d_bits_opcode(out_d_bits_opcode), .out_d_bits_param(out_d_bits_param),
      .out_d_bits_size(out_d_bits_size), .out_d_bits_source(out_d_bits_source),
      .out_d_bits_sink(out_d_bits_sink), .out_d_bits_denied(out_d_bits_denied),
      .out_d_bits_data(out_d_bits_data), .out_d_bits_corrupt(out_d_bits_corrupt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic set_a0(input logic v, input logic [2:0] op, input logic [2:0] sz);
      in0_a_valid = v; in0_a_bits_opcode = op; in0_a_bits_size = sz;
   endtask

   task automatic set_a1(input logic v, input logic [2:0] op, input logic [2:0] sz);
      in1_a_valid = v; in1_a_bits_opcode = op; in1_a_bits_size = sz;
   endtask

   // Expected A-side outputs for one cycle.
   task automatic chk_a(input string tag, input logic ev, input logic er0, input logic er1,
                        input logic [4:0] esrc);
      chk({tag, "_valid"}, 64'(out_a_valid), 64'(ev));
      chk({tag, "_rdy0"}, 64'(in0_a_ready), 64'(er0));
      chk({tag, "_rdy1"}, 64'(in1_a_ready), 64'(er1));
      if (ev) chk({tag, "_src"}, 64'(out_a_bits_source), 64'(esrc));
   endtask

   function automatic int msg_beats(input int op, input int sz);
      if (op >= 4 || sz <= 3) return 1;
      return 2 ** (sz - 3);
   endfunction

   typedef struct {
      logic       v0;
      logic [2:0] op0, sz0;
      logic       v1;
      logic [2:0] op1, sz1;
      logic       rdy;
      logic       e_v, e_r0, e_r1;
      logic [4:0] e_src;
   } vec_t;

   vec_t tbl[13];

   int m_lock, m_left, m_ptr, g, b;
   logic ev, er0, er1;

   initial begin
      // Four alternating Gets, then an 8-beat Put from client 0 holding off client 1.
      for (int i = 0; i < 4; i++)
         tbl[i] = '{1'b1, 3'd4, 3'd0, 1'b1, 3'd4, 3'd0, 1'b1, 1'b1,
                    (i % 2 == 0), (i % 2 == 1), (i % 2 == 0) ? 5'h05 : 5'h1A};
      for (int i = 4; i < 12; i++)
         tbl[i] = '{1'b1, 3'd0, 3'd6, 1'b1, 3'd4, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'h05};
      tbl[12] = '{1'b1, 3'd0, 3'd6, 1'b1, 3'd4, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'h1A};

      reset = 1'b1;
      set_a0(1'b1, 3'd4, 3'd0); set_a1(1'b1, 3'd4, 3'd0);
      in0_a_bits_param = 3'd1; in0_a_bits_source = 4'h5; in0_a_bits_address = 32'h1000;
      in0_a_bits_mask = 8'hFF; in0_a_bits_data = 64'hA0A0; in0_a_bits_corrupt = 1'b0;
      in1_a_bits_param = 3'd2; in1_a_bits_source = 4'hA; in1_a_bits_address = 32'h2000;
      in1_a_bits_mask = 8'h0F; in1_a_bits_data = 64'hB1B1; in1_a_bits_corrupt = 1'b1;
      out_a_ready = 1'b1;
      out_d_valid = 1'b1; out_d_bits_source = 5'h13; out_d_bits_opcode = 3'd1;
      out_d_bits_param = 2'd0; out_d_bits_size = 3'd3; out_d_bits_sink = 3'd2;
      out_d_bits_denied = 1'b0; out_d_bits_data = 64'hD00D; out_d_bits_corrupt = 1'b0;
      in0_d_ready = 1'b1; in1_d_ready = 1'b1;

      // Reset state with every input asserted.
      repeat (2) @(negedge clock);
      chk_a("rst", 1'b0, 1'b0, 1'b0, 5'h0);
      chk("rst_d0v", 64'(in0_d_valid), 64'd0);
      chk("rst_d1v", 64'(in1_d_valid), 64'd0);
      chk("rst_dr", 64'(out_d_ready), 64'd0);
      reset = 1'b0;
      out_d_valid = 1'b0;

      // Table: alternation, then burst lock and handoff.
      for (int i = 0; i < 13; i++) begin
         if (i > 0) @(negedge clock);
         set_a0(tbl[i].v0, tbl[i].op0, tbl[i].sz0);
         set_a1(tbl[i].v1, tbl[i].op1, tbl[i].sz1);
         out_a_ready = tbl[i].rdy;
         #1;
         chk_a($sformatf("tbl%0d", i), tbl[i].e_v, tbl[i].e_r0, tbl[i].e_r1, tbl[i].e_src);
      end

      // Burst stall: client 0 drops valid mid-message, client 1 must stay locked out.
      @(negedge clock); set_a0(1'b1, 3'd0, 3'd5); set_a1(1'b1, 3'd4, 3'd0); #1;
      chk_a("stall_b1", 1'b1, 1'b1, 1'b0, 5'h05);
      @(negedge clock); #1;
      chk_a("stall_b2", 1'b1, 1'b1, 1'b0, 5'h05);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock); in0_a_valid = 1'b0; #1;
         chk("stall_gap_valid", 64'(out_a_valid), 64'd0);
         chk("stall_gap_rdy1", 64'(in1_a_ready), 64'd0);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clock); in0_a_valid = 1'b1; #1;
         chk_a("stall_tail", 1'b1, 1'b1, 1'b0, 5'h05);
      end
      @(negedge clock); #1;
      chk_a("stall_next", 1'b1, 1'b0, 1'b1, 5'h1A);

      // D routing to client 1 with back-pressure.
      @(negedge clock); set_a0(1'b0, 3'd4, 3'd0); set_a1(1'b0, 3'd4, 3'd0);
      out_d_valid = 1'b1; out_d_bits_source = 5'h13; in1_d_ready = 1'b0; in0_d_ready = 1'b1; #1;
      chk("d_v1", 64'(in1_d_valid), 64'd1);
      chk("d_v0", 64'(in0_d_valid), 64'd0);
      chk("d_src1", 64'(in1_d_bits_source), 64'h3);
      chk("d_rdy_lo", 64'(out_d_ready), 64'd0);
      @(negedge clock); in1_d_ready = 1'b1; #1;
      chk("d_rdy_hi", 64'(out_d_ready), 64'd1);
      chk("d_v0b", 64'(in0_d_valid), 64'd0);
      out_d_valid = 1'b0;

      // Reset mid-burst: after 3 of 4 client-1 beats, reset abandons the message.
      for (int i = 0; i < 3; i++) begin
         @(negedge clock); set_a1(1'b1, 3'd0, 3'd5); #1;
         chk_a("rb_beat", 1'b1, 1'b0, 1'b1, 5'h1A);
      end
      @(negedge clock); reset = 1'b1; set_a0(1'b1, 3'd4, 3'd0); out_d_valid = 1'b1; #1;
      chk_a("rb_in_rst", 1'b0, 1'b0, 1'b0, 5'h0);
      chk("rb_d0v", 64'(in0_d_valid), 64'd0);
      chk("rb_d1v", 64'(in1_d_valid), 64'd0);
      chk("rb_dr", 64'(out_d_ready), 64'd0);
      @(negedge clock); reset = 1'b0; out_d_valid = 1'b0;
      set_a0(1'b1, 3'd4, 3'd0); set_a1(1'b1, 3'd4, 3'd0); #1;
      chk_a("rb_fresh", 1'b1, 1'b1, 1'b0, 5'h05);
      @(negedge clock); #1;
      chk_a("rb_fresh2", 1'b1, 1'b0, 1'b1, 5'h1A);

      // Concurrent A grant (client 1) and D return (client 0).
      @(negedge clock); set_a0(1'b0, 3'd4, 3'd0); set_a1(1'b1, 3'd4, 3'd0);
      out_d_valid = 1'b1; out_d_bits_source = 5'h02; in0_d_ready = 1'b1; in1_d_ready = 1'b0; #1;
      chk_a("conc_a", 1'b1, 1'b0, 1'b1, 5'h1A);
      chk("conc_d0v", 64'(in0_d_valid), 64'd1);
      chk("conc_d1v", 64'(in1_d_valid), 64'd0);
      chk("conc_dr", 64'(out_d_ready), 64'd1);

      // Randomized traffic against the reference model.
      @(negedge clock); reset = 1'b1;
      @(negedge clock); reset = 1'b0;
      m_lock = -1; m_left = 0; m_ptr = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clock);
         in0_a_valid = ($urandom_range(3) != 0);
         in1_a_valid = ($urandom_range(3) != 0);
         in0_a_bits_opcode = 3'($urandom); in0_a_bits_size = 3'($urandom_range(6));
         in1_a_bits_opcode = 3'($urandom); in1_a_bits_size = 3'($urandom_range(6));
         in0_a_bits_param = 3'($urandom); in1_a_bits_param = 3'($urandom);
         in0_a_bits_source = 4'($urandom); in1_a_bits_source = 4'($urandom);
         in0_a_bits_address = $urandom; in1_a_bits_address = $urandom;
         in0_a_bits_mask = 8'($urandom); in1_a_bits_mask = 8'($urandom);
         in0_a_bits_data = {$urandom, $urandom}; in1_a_bits_data = {$urandom, $urandom};
         in0_a_bits_corrupt = 1'($urandom); in1_a_bits_corrupt = 1'($urandom);
         out_a_ready = ($urandom_range(3) != 0);
         out_d_valid = 1'($urandom); out_d_bits_source = 5'($urandom);
         out_d_bits_opcode = 3'($urandom); out_d_bits_param = 2'($urandom);
         out_d_bits_size = 3'($urandom); out_d_bits_sink = 3'($urandom);
         out_d_bits_denied = 1'($urandom); out_d_bits_corrupt = 1'($urandom);
         out_d_bits_data = {$urandom, $urandom};
         in0_d_ready = 1'($urandom); in1_d_ready = 1'($urandom);
         #1;

         if (m_lock >= 0) g = m_lock;
         else if (in0_a_valid && in1_a_valid) g = m_ptr;
         else if (in1_a_valid) g = 1;
         else if (in0_a_valid) g = 0;
         else g = -1;
         ev  = (g == 0) ? in0_a_valid : (g == 1) ? in1_a_valid : 1'b0;
         er0 = (g == 0) && out_a_ready;
         er1 = (g == 1) && out_a_ready;
         chk("rnd_a_valid", 64'(out_a_valid), 64'(ev));
         chk("rnd_rdy0", 64'(in0_a_ready), 64'(er0));
         chk("rnd_rdy1", 64'(in1_a_ready), 64'(er1));
         if (ev) begin
            if (g == 0) begin
               chk("rnd_a_src", 64'(out_a_bits_source), 64'({1'b0, in0_a_bits_source}));
               chk("rnd_a_addr", 64'(out_a_bits_address), 64'(in0_a_bits_address));
               chk("rnd_a_data", out_a_bits_data, in0_a_bits_data);
               chk("rnd_a_flds", 64'({out_a_bits_opcode, out_a_bits_param, out_a_bits_size,
                                      out_a_bits_mask, out_a_bits_corrupt}),
                   64'({in0_a_bits_opcode, in0_a_bits_param, in0_a_bits_size,
                        in0_a_bits_mask, in0_a_bits_corrupt}));
            end else begin
               chk("rnd_a_src", 64'(out_a_bits_source), 64'({1'b1, in1_a_bits_source}));
               chk("rnd_a_addr", 64'(out_a_bits_address), 64'(in1_a_bits_address));
               chk("rnd_a_data", out_a_bits_data, in1_a_bits_data);
               chk("rnd_a_flds", 64'({out_a_bits_opcode, out_a_bits_param, out_a_bits_size,
                                      out_a_bits_mask, out_a_bits_corrupt}),
                   64'({in1_a_bits_opcode, in1_a_bits_param, in1_a_bits_size,
                        in1_a_bits_mask, in1_a_bits_corrupt}));
            end
         end

         chk("rnd_d0v", 64'(in0_d_valid), 64'(out_d_valid && (out_d_bits_source[4] == 1'b0)));
         chk("rnd_d1v", 64'(in1_d_valid), 64'(out_d_valid && (out_d_bits_source[4] == 1'b1)));
         chk("rnd_dr", 64'(out_d_ready),
             64'(out_d_bits_source[4] ? in1_d_ready : in0_d_ready));
         chk("rnd_d0f", 64'({in0_d_bits_opcode, in0_d_bits_param, in0_d_bits_size,
                             in0_d_bits_source, in0_d_bits_sink, in0_d_bits_denied,
                             in0_d_bits_corrupt}),
             64'({out_d_bits_opcode, out_d_bits_param, out_d_bits_size,
                  out_d_bits_source[3:0], out_d_bits_sink, out_d_bits_denied,
                  out_d_bits_corrupt}));
         chk("rnd_d1f", 64'({in1_d_bits_opcode, in1_d_bits_param, in1_d_bits_size,
                             in1_d_bits_source, in1_d_bits_sink, in1_d_bits_denied,
                             in1_d_bits_corrupt}),
             64'({out_d_bits_opcode, out_d_bits_param, out_d_bits_size,
                  out_d_bits_source[3:0], out_d_bits_sink, out_d_bits_denied,
                  out_d_bits_corrupt}));
         chk("rnd_d0data", in0_d_bits_data, out_d_bits_data);
         chk("rnd_d1data", in1_d_bits_data, out_d_bits_data);

         // Message bookkeeping: a message ends after its beat count is consumed.
         if (ev && out_a_ready) begin
            if (m_lock < 0) begin
               b = (g == 0) ? msg_beats(int'(in0_a_bits_opcode), int'(in0_a_bits_size))
                            : msg_beats(int'(in1_a_bits_opcode), int'(in1_a_bits_size));
               if (b > 1) begin
                  m_lock = g;
                  m_left = b - 1;
               end else begin
                  m_ptr = 1 - g;
               end
            end else begin
               m_left--;
               if (m_left == 0) begin
                  m_ptr  = 1 - m_lock;
                  m_lock = -1;
               end
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tl_a_arbiter_2.md
TL_A_ARBITER_2 -- requirements
Module: tl_a_arbiter_2

Interface
REQ-001 Parameters: none; two clients, 64-bit data (8-byte beats), 4-bit client source, 32-bit address are fixed.
REQ-002 clock  in  1  sole clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 in0_a_valid/ready, in0_a_bits_{opcode 3, param 3, size 3, source 4, address 32, mask 8, data 64, corrupt 1}  in/out  client 0 A channel.
REQ-005 in1_a_*  in/out  same widths  client 1 A channel.
REQ-006 in0_d_valid/ready, in0_d_bits_{opcode 3, param 2, size 3, source 4, sink 3, denied 1, data 64, corrupt 1}  out/in  client 0 D channel.
REQ-007 in1_d_*  out/in  same widths  client 1 D channel.
REQ-008 out_a_*  out/in  as in0_a_* except source 5 bits  manager A channel.
REQ-009 out_d_*  in/out  as in0_d_* except source 5 bits  manager D channel.

Function
REQ-010 out_a_bits_source SHALL be {granted client index, client source[3:0]}; all other A fields SHALL pass unmodified from the granted client.
REQ-011 A beats per message SHALL be 1 for opcodes 4-7 (no data), else 1 for size<=3, else 2^(size-3) (max 16).
REQ-012 States: IDLE and BURST; 1-bit round-robin pointer ptr; 4-bit beats-remaining counter cnt.
REQ-013 In IDLE, the grant SHALL be decided combinationally in the same cycle: one valid client wins; both valid -> client ptr wins; zero added latency.
REQ-014 out_a_valid SHALL equal the granted client's valid; only the granted client's a_ready SHALL follow out_a_ready; the other client's a_ready SHALL be 0.
REQ-015 On an accepted first beat of a multi-beat message: state->BURST, cnt<=beats-1, grant locked to that client.
REQ-016 In BURST, no other client SHALL be granted; each accepted beat decrements cnt; acceptance of the beat with cnt==1 -> IDLE.
REQ-017 On completion of any message (single-beat accept in IDLE, or final beat in BURST), ptr SHALL become the complement of the client just served.
REQ-018 In BURST with granted client valid low, out_a_valid SHALL be 0 and the lock SHALL be held (no re-arbitration).
REQ-019 D routing SHALL be stateless: out_d_source[4] selects the client; that client's d_valid=out_d_valid, other's d_valid=0; out_d_ready = selected client's d_ready.
REQ-020 in*_d_bits_source SHALL be out_d_bits_source[3:0]; other D fields pass unmodified to both clients.
REQ-021 A and D paths SHALL be independent; simultaneous A grant and D return in one cycle SHALL both proceed.
REQ-022 in*_a_ready SHALL never be 1 for an ungranted client; a client SHALL never observe ready without its own valid being considered for grant.

Reset
REQ-023 While reset is high: state=IDLE, ptr=0, cnt=0, out_a_valid=0, in0/in1_a_ready=0, in0/in1_d_valid=0, out_d_ready=0.
REQ-024 Reset asserted mid-BURST SHALL abandon the message immediately; after deassertion arbitration restarts from IDLE with ptr=0.

Structure
REQ-025 Shared package tl_arb_pkg SHALL hold the opcode constants, the beats-from-(opcode,size) function, and the IDLE/BURST state enum.
REQ-026 One sub-module tl_rr_grant_2 (2-way round-robin grant from valids+ptr) is natural; the rest is flat.

Verification
REQ-027 Both clients issue single-beat Get (opcode 4) every cycle, out_a_ready=1 -> grants alternate 0,1,0,1; out sources 0x0s,0x1s.
REQ-028 Client 0 PutFullData size=6 (8 beats) while client 1 valid -> 8 consecutive client-0 beats, client 1 granted on cycle 9.
REQ-029 Mid-burst client-0 valid drops 3 cycles with client 1 valid -> out_a_valid=0 those cycles, in1_a_ready=0, burst resumes.
REQ-030 out_d source 0x13, valid=1, in1_d_ready=0 then 1 -> in1_d_valid=1 source 0x3, out_d_ready tracks in1_d_ready, in0_d_valid=0.
REQ-031 Reset pulse after beat 3 of a 4-beat Put -> all valids/readies 0 during reset; next request granted as fresh IDLE single arbitration with ptr=0.
REQ-032 Simultaneous client-1 Get grant and D return to client 0 in one cycle -> both handshakes complete in that cycle.
